// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues word requests to instruction memory, streams
// responses into the prefetch buffer, tracks buffer occupancy and handles redirects.
module fetch_controller #(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        buf_write_en,
  output logic [31:0] buf_data_in,
  input  logic [1:0]  buf_read_en,
  output logic        buf_flush,
  output logic        buf_skip_half,
  output logic [3:0]  hw_count
);

  localparam int OUT_W = (MAX_OUTSTANDING < 1) ? 1 : $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    FETCH = 2'b01,
    FLUSH = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_addr_q, fetch_addr_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [3:0]        hw_count_q, hw_count_d;
  logic              pending_skip_q, pending_skip_d;
  logic              buf_flush_q, buf_flush_d;

  logic              in_fetch;
  logic              grant;
  logic [31:0]       fill_need;
  logic signed [5:0] wr_hw;
  logic signed [5:0] rd_hw;
  logic signed [5:0] hw_next_s;
  logic              unused_target_lsb;

  assign unused_target_lsb = branch_target[0];

  function automatic logic [3:0] clamp_hw(input logic signed [5:0] v);
    if (v < 6'sd0)      return 4'd0;
    else if (v > 6'sd8) return 4'd8;
    else                return v[3:0];
  endfunction

  always_comb begin
    in_fetch  = (state_q == FETCH);
    // Buffer must have room for every in-flight word plus the one about to be requested.
    fill_need = 32'(hw_count_q) + (32'(outstanding_q) << 1) + 32'd2;
    imem_req  = !rst && in_fetch && fetch_en && !branch_valid &&
                (32'(outstanding_q) < MAX_OUTSTANDING) && (fill_need <= 32'd8);
    imem_addr = fetch_addr_q;
    grant     = imem_req && imem_gnt;

    buf_write_en  = !rst && in_fetch && imem_rvalid;
    buf_data_in   = imem_rdata;
    buf_skip_half = buf_write_en && pending_skip_q;
    buf_flush     = buf_flush_q;
    hw_count      = hw_count_q;

    wr_hw = 6'sd0;
    if (buf_write_en) wr_hw = pending_skip_q ? 6'sd1 : 6'sd2;
    unique case (buf_read_en)
      2'b10:   rd_hw = 6'sd1;
      2'b11:   rd_hw = 6'sd2;
      default: rd_hw = 6'sd0;
    endcase
    hw_next_s = $signed({2'b00, hw_count_q}) + wr_hw - rd_hw;

    outstanding_d = outstanding_q;
    if (grant && !imem_rvalid)
      outstanding_d = outstanding_q + 1'b1;
    else if (!grant && imem_rvalid && (outstanding_q != '0))
      outstanding_d = outstanding_q - 1'b1;

    fetch_addr_d   = grant ? fetch_addr_q + 32'd4 : fetch_addr_q;
    pending_skip_d = buf_write_en ? 1'b0 : pending_skip_q;
    hw_count_d     = hw_count_q;
    buf_flush_d    = branch_valid;
    state_d        = state_q;

    unique case (state_q)
      FETCH: begin
        hw_count_d = clamp_hw(hw_next_s);
        state_d    = FETCH;
      end
      FLUSH: begin
        state_d = (outstanding_d == '0) ? FETCH : FLUSH;
      end
      default: state_d = FETCH;
    endcase

    // A redirect discards buffered words and anything still in flight.
    if (branch_valid) begin
      fetch_addr_d   = {branch_target[31:2], 2'b00};
      pending_skip_d = branch_target[1];
      hw_count_d     = 4'd0;
      state_d        = (outstanding_d != '0) ? FLUSH : FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FETCH;
      fetch_addr_q   <= BOOT_ADDR;
      outstanding_q  <= '0;
      hw_count_q     <= 4'd0;
      pending_skip_q <= 1'b0;
      buf_flush_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_addr_q   <= fetch_addr_d;
      outstanding_q  <= outstanding_d;
      hw_count_q     <= hw_count_d;
      pending_skip_q <= pending_skip_d;
      buf_flush_q    <= buf_flush_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a request-queue reference model predicts each
// cycle's outputs and buffer writes; a monitor pops and compares them at the falling edge.
module tb_fetch_controller;

  localparam logic [31:0] BOOT  = 32'h0000_0000;
  localparam int          MAXO  = 2;
  localparam int          NCYC  = 2000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fetch_en, branch_valid, imem_gnt, imem_rvalid;
  logic [31:0] branch_target, imem_rdata, imem_addr, buf_data_in;
  logic [1:0]  buf_read_en;
  logic        imem_req, buf_write_en, buf_flush, buf_skip_half;
  logic [3:0]  hw_count;

  logic        w_fe, w_br, w_gnt, w_rv, w_req, w_wr, w_flush, w_skip;
  logic [31:0] w_tgt, w_rdata, w_addr, w_din;
  logic [1:0]  w_rd;
  logic [3:0]  w_hw;

  fetch_controller #(.BOOT_ADDR(BOOT), .MAX_OUTSTANDING(MAXO)) u_dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .branch_valid(branch_valid),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .buf_write_en(buf_write_en), .buf_data_in(buf_data_in), .buf_read_en(buf_read_en),
    .buf_flush(buf_flush), .buf_skip_half(buf_skip_half), .hw_count(hw_count)
  );

  fetch_controller #(.BOOT_ADDR(32'hFFFF_FFFC), .MAX_OUTSTANDING(2)) u_wrap (
    .clk(clk), .rst(rst), .fetch_en(w_fe), .branch_valid(w_br),
    .branch_target(w_tgt), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rvalid(w_rv), .imem_rdata(w_rdata),
    .buf_write_en(w_wr), .buf_data_in(w_din), .buf_read_en(w_rd),
    .buf_flush(w_flush), .buf_skip_half(w_skip), .hw_count(w_hw)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic        rst_cyc;
    logic        req;
    logic [31:0] addr;
    logic        wr;
    logic        flush;
    logic [3:0]  hw;
  } cyc_t;

  typedef struct packed {
    logic [31:0] data;
    logic        skip;
  } wr_t;

  cyc_t cyc_q[$];
  wr_t  wr_q[$];

  // Reference model: in-flight requests are a queue of "still wanted" flags.
  logic [31:0] m_addr;
  bit          live_q[$];
  int          m_hw;
  bit          m_skip;
  bit          m_flush_next;

  initial begin
    rst = 1'b1; fetch_en = 1'b0; branch_valid = 1'b0; branch_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; buf_read_en = 2'b00;
    m_addr = BOOT; m_hw = 0; m_skip = 0; m_flush_next = 0;
    @(posedge clk); #1;
    for (int n = 0; n < NCYC; n++) begin
      bit r, fe, br, g, rv, flushing, ereq, ewr;
      logic [31:0] tgt, rdat;
      logic [1:0]  rd;
      int          rd_amt;
      flushing = 0;
      foreach (live_q[i]) if (!live_q[i]) flushing = 1;
      r = 0; fe = 1; br = 0; tgt = '0; g = 1; rd = 2'b00;
      rv = (live_q.size() > 0);
      rdat = $urandom;
      if (n < 3 || n == 100 || n == 101) r = 1;
      else if (n < 40) begin end
      else if (n < 45) rd = (n == 40) ? 2'b11 : 2'b00;
      else if (n < 70) begin
        if (n == 50) begin br = 1; tgt = 32'h0000_0102; end
      end
      else if (n < 74) rd = 2'b11;
      else if (n < 78) rv = 0;
      else if (n == 78) begin br = 1; tgt = 32'h0000_0206; rv = 0; end
      else if (n < 90) begin end
      else if (n < 100) g = 0;
      else begin
        fe  = ($urandom_range(0, 9) != 0);
        br  = ($urandom_range(0, 19) == 0);
        tgt = $urandom;
        if ($urandom_range(0, 3) == 0) tgt[31:4] = '1;
        tgt[0] = 1'b0;
        g   = ($urandom_range(0, 4) < 3);
        rv  = (live_q.size() > 0) && ($urandom_range(0, 1) == 1);
        rd  = 2'($urandom_range(0, 3));
      end
      rd_amt = (rd == 2'b10) ? 1 : (rd == 2'b11) ? 2 : 0;
      if (!flushing && !br && !r && rd_amt > m_hw) begin
        rd = 2'b00; rd_amt = 0;
      end

      rst = r; fetch_en = fe; branch_valid = br; branch_target = tgt;
      imem_gnt = g; imem_rvalid = rv; imem_rdata = rdat; buf_read_en = rd;

      if (r) begin
        cyc_q.push_back('{rst_cyc: 1'b1, req: 1'b0, addr: 32'h0, wr: 1'b0, flush: 1'b0, hw: 4'h0});
        m_addr = BOOT; live_q.delete(); m_hw = 0; m_skip = 0; m_flush_next = 0;
      end else begin
        ereq = !flushing && fe && !br && (live_q.size() < MAXO) &&
               (m_hw + 2 * live_q.size() + 2 <= 8);
        ewr  = rv && live_q[0];
        cyc_q.push_back('{rst_cyc: 1'b0, req: ereq, addr: m_addr, wr: ewr,
                          flush: m_flush_next, hw: 4'(m_hw)});
        if (ewr) wr_q.push_back('{data: rdat, skip: m_skip});
        if (rv) void'(live_q.pop_front());
        if (br) m_hw = 0;
        else if (!flushing) m_hw = m_hw + (ewr ? (m_skip ? 1 : 2) : 0) - rd_amt;
        if (ewr) m_skip = 0;
        if (ereq && g) begin
          m_addr = m_addr + 32'd4;
          live_q.push_back(1'b1);
        end
        if (br) begin
          foreach (live_q[i]) live_q[i] = 1'b0;
          m_addr = {tgt[31:2], 2'b00};
          m_skip = tgt[1];
        end
        m_flush_next = br;
      end
      @(posedge clk); #1;
    end
    fetch_en = 1'b0; imem_rvalid = 1'b0; branch_valid = 1'b0; buf_read_en = 2'b00;
    check("pending_writes", 32'(wr_q.size()), 32'd0);
    check("pending_cycles", 32'(cyc_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    forever begin
      cyc_t e;
      wr_t  w;
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        check("imem_req", 32'(imem_req), 32'(e.req));
        if (e.req && imem_req) check("imem_addr", imem_addr, e.addr);
        check("buf_write_en", 32'(buf_write_en), 32'(e.wr));
        if (!e.rst_cyc) begin
          check("buf_flush", 32'(buf_flush), 32'(e.flush));
          check("hw_count", 32'(hw_count), 32'(e.hw));
        end
        if (buf_write_en) begin
          if (wr_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got data %h expected no write", buf_data_in);
          end else begin
            w = wr_q.pop_front();
            check("buf_data_in", buf_data_in, w.data);
            check("buf_skip_half", 32'(buf_skip_half), 32'(w.skip));
          end
        end else begin
          check("skip_idle", 32'(buf_skip_half), 32'd0);
        end
      end
    end
  end

  initial begin
    int k;
    w_fe = 1'b1; w_gnt = 1'b1; w_br = 1'b0; w_tgt = '0;
    w_rv = 1'b0; w_rdata = '0; w_rd = 2'b00;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rst !== 1'b0 && k < 20);
    if (rst !== 1'b0) begin
      n_checks++;
      $display("FAIL wrap_reset_release: got rst %b expected 0 within 20 cycles", rst);
    end else begin
      check("wrap_req0", 32'(w_req), 32'd1);
      check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      check("wrap_req1", 32'(w_req), 32'd1);
      check("wrap_addr1", w_addr, 32'h0000_0000);
      @(negedge clk);
      check("wrap_req_limit", 32'(w_req), 32'd0);
    end
  end

endmodule
